// File: rtl/sipo_y_ctrl_if.sv
// Control/stream bundle between the Y-operand chain sequencer and its environment.
// The slave side is the sequencer; the master side drives start/abort and the input stream.
interface sipo_y_ctrl_if #(
   parameter int PE_NUM  = 8,
   parameter int REG_NUM = 32,
   parameter int PASS_W  = 8
);
   localparam int REG_W = $clog2(REG_NUM);
   localparam int PE_W  = $clog2(PE_NUM);

   logic              start;
   logic [PASS_W-1:0] num_pass;
   logic              abort;
   logic              s_in_v;
   logic              s_in_rdy;
   logic              srl_ce;
   logic              srl_sel;
   logic [REG_W-1:0]  reg_idx;
   logic [PE_W-1:0]   pe_idx;
   logic [PASS_W-1:0] pass_idx;
   logic              p_out_v;
   logic              busy;
   logic              done;

   modport master (
      output start, num_pass, abort, s_in_v,
      input  s_in_rdy, srl_ce, srl_sel, reg_idx, pe_idx, pass_idx, p_out_v, busy, done
   );

   modport slave (
      input  start, num_pass, abort, s_in_v,
      output s_in_rdy, srl_ce, srl_sel, reg_idx, pe_idx, pass_idx, p_out_v, busy, done
   );
endinterface

// File: rtl/sipo_y_ctrl.sv
// Sequencer for the Y-operand SRL chain: loads PE_NUM*REG_NUM words, then
// recirculates the chain for num_pass full passes, then pulses done.
module sipo_y_ctrl #(
   parameter int PE_NUM  = 8,
   parameter int REG_NUM = 32,
   parameter int PASS_W  = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   sipo_y_ctrl_if.slave  ctrl
);
   localparam int REG_W = $clog2(REG_NUM);
   localparam int PE_W  = $clog2(PE_NUM);
   localparam logic [REG_W-1:0] REG_LAST = REG_W'(REG_NUM - 1);
   localparam logic [PE_W-1:0]  PE_LAST  = PE_W'(PE_NUM - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ROTATE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            r_state;
   logic [REG_W-1:0]  r_reg_idx;
   logic [PE_W-1:0]   r_pe_idx;
   logic [PASS_W-1:0] r_pass_idx;
   logic [PASS_W-1:0] r_num_pass;

   logic w_accept;
   logic w_advance;
   logic w_reg_last;
   logic w_sweep_end;
   logic w_pass_last;

   assign w_accept    = (r_state == ST_LOAD) & ctrl.s_in_v;
   assign w_advance   = w_accept | (r_state == ST_ROTATE);
   assign w_reg_last  = (r_reg_idx == REG_LAST);
   assign w_sweep_end = w_reg_last & (r_pe_idx == PE_LAST);
   assign w_pass_last = (r_pass_idx == (r_num_pass - PASS_W'(1)));

   // Power-of-two depths let the slot/stage counters wrap to 0 on their own
   // at the end of a sweep, so no explicit clear is needed there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_reg_idx  <= '0;
         r_pe_idx   <= '0;
         r_pass_idx <= '0;
         r_num_pass <= '0;
      end else if (ctrl.abort) begin
         r_state    <= ST_IDLE;
         r_reg_idx  <= '0;
         r_pe_idx   <= '0;
         r_pass_idx <= '0;
      end else begin
         if (w_advance) begin
            r_reg_idx <= r_reg_idx + REG_W'(1);
            if (w_reg_last) begin
               r_pe_idx <= r_pe_idx + PE_W'(1);
            end
         end
         unique case (r_state)
            ST_IDLE: begin
               if (ctrl.start) begin
                  r_num_pass <= ctrl.num_pass;
                  r_reg_idx  <= '0;
                  r_pe_idx   <= '0;
                  r_pass_idx <= '0;
                  r_state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_accept && w_sweep_end) begin
                  r_state <= (r_num_pass == '0) ? ST_DONE : ST_ROTATE;
               end
            end
            ST_ROTATE: begin
               if (w_sweep_end) begin
                  if (w_pass_last) begin
                     r_pass_idx <= '0;
                     r_state    <= ST_DONE;
                  end else begin
                     r_pass_idx <= r_pass_idx + PASS_W'(1);
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // srl_ce follows s_in_v directly so a stalled LOAD never shifts the chain.
   assign ctrl.s_in_rdy = (r_state == ST_LOAD);
   assign ctrl.srl_sel  = (r_state == ST_ROTATE);
   assign ctrl.srl_ce   = w_advance;
   assign ctrl.p_out_v  = (r_state == ST_ROTATE);
   assign ctrl.busy     = (r_state != ST_IDLE);
   assign ctrl.done     = (r_state == ST_DONE);
   assign ctrl.reg_idx  = r_reg_idx;
   assign ctrl.pe_idx   = r_pe_idx;
   assign ctrl.pass_idx = r_pass_idx;
endmodule

// File: tb/tb_sipo_y_ctrl.sv
// Directed bench for sipo_y_ctrl: full frames, backpressure, zero passes,
// abort, asynchronous reset and counter wrap, all against closed-form expectations.
module tb_sipo_y_ctrl;
   localparam int PE_NUM  = 8;
   localparam int REG_NUM = 32;
   localparam int PASS_W  = 8;
   localparam int REG_W   = $clog2(REG_NUM);
   localparam int PE_W    = $clog2(PE_NUM);
   localparam int WORDS   = PE_NUM * REG_NUM;
   localparam int VEC_W   = 6 + REG_W + PE_W + PASS_W;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   sipo_y_ctrl_if #(.PE_NUM(PE_NUM), .REG_NUM(REG_NUM), .PASS_W(PASS_W)) bus ();

   sipo_y_ctrl #(.PE_NUM(PE_NUM), .REG_NUM(REG_NUM), .PASS_W(PASS_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   // Observed vector: {rdy, ce, sel, p_out_v, busy, done, reg_idx, pe_idx, pass_idx}
   function automatic logic [VEC_W-1:0] pack_dut();
      return {bus.s_in_rdy, bus.srl_ce, bus.srl_sel, bus.p_out_v, bus.busy, bus.done,
              bus.reg_idx, bus.pe_idx, bus.pass_idx};
   endfunction

   function automatic logic [VEC_W-1:0] mk(input bit rdy, input bit ce, input bit sel,
                                           input bit pv, input bit bsy, input bit dn,
                                           input int reg_i, input int pe_i, input int pass_i);
      return {rdy, ce, sel, pv, bsy, dn, REG_W'(reg_i), PE_W'(pe_i), PASS_W'(pass_i)};
   endfunction

   task automatic chk(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after a rising edge with the DUT idle; start is raised
   // in this cycle (cycle 0). Runs through DONE plus one trailing IDLE cycle.
   task automatic run_frame(input int np, input bit toggle, input string name);
      int load_len;
      int d;
      int acc;
      int r;
      bit v;
      logic [VEC_W-1:0] exp;
      load_len     = toggle ? (2 * WORDS - 1) : WORDS;
      d            = load_len + np * WORDS + 1;
      bus.start    = 1'b1;
      bus.num_pass = PASS_W'(np);
      bus.abort    = 1'b0;
      bus.s_in_v   = toggle ? 1'b0 : 1'b1;
      #1;
      chk({name, " c0"}, pack_dut(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int c = 1; c <= d + 1; c++) begin
         step();
         bus.start = (c == 5) || (c == d);
         if (c == 1) bus.num_pass = PASS_W'(np + 3);
         v          = toggle ? (c % 2 == 1) : 1'b1;
         bus.s_in_v = v;
         #1;
         if (c <= load_len) begin
            acc = toggle ? (c / 2) : (c - 1);
            exp = mk(1, v, 0, 0, 1, 0, acc % REG_NUM, (acc / REG_NUM) % PE_NUM, 0);
         end else if (c < d) begin
            r   = c - load_len - 1;
            exp = mk(0, 1, 1, 1, 1, 0, r % REG_NUM, (r / REG_NUM) % PE_NUM, r / WORDS);
         end else if (c == d) begin
            exp = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
         end else begin
            exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
         end
         chk($sformatf("%s c%0d", name, c), pack_dut(), exp);
      end
      bus.start = 1'b0;
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.num_pass = '0;
      bus.abort    = 1'b0;
      bus.s_in_v   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", pack_dut(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      step();

      run_frame(2, 1'b0, "full");
      step();
      run_frame(1, 1'b1, "bp");
      step();

      // Abort with a simultaneous start at ROTATE cycle 100.
      bus.start    = 1'b1;
      bus.num_pass = PASS_W'(3);
      bus.s_in_v   = 1'b1;
      for (int c = 1; c <= WORDS + 101; c++) begin
         step();
         bus.start = 1'b0;
      end
      bus.abort = 1'b1;
      bus.start = 1'b1;
      #1;
      chk("abort_pre", pack_dut(), mk(0, 1, 1, 1, 1, 0, 100 % REG_NUM, 100 / REG_NUM, 0));
      step();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      #1;
      chk("abort_idle1", pack_dut(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      run_frame(0, 1'b0, "np0");

      // Abort together with start while idle: start must be dropped.
      step();
      bus.abort = 1'b1;
      bus.start = 1'b1;
      step();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      #1;
      chk("abort_idle_start", pack_dut(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Asynchronous reset in the middle of ROTATE.
      step();
      bus.start    = 1'b1;
      bus.num_pass = PASS_W'(2);
      bus.s_in_v   = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         step();
         bus.start = 1'b0;
      end
      #1;
      chk("pre_reset", pack_dut(), mk(0, 1, 1, 1, 1, 0, 43 % REG_NUM, 43 / REG_NUM, 0));
      rst_n = 1'b0;
      #1;
      chk("async_reset", pack_dut(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         chk($sformatf("post_reset c%0d", c), pack_dut(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
